// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
//
// Contents:
//   BAUD_DIV_9600   - divider for 9600 baud from a 50 MHz clock
//   BAUD_DIV_115200 - divider for 115200 baud from a 50 MHz clock
//   uart_state_e    - transmitter frame state
//   cnt_width()     - bits needed to hold a count of 0..max_val (minimum 1)
//
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.

package uart_pkg;

  localparam int unsigned BAUD_DIV_9600   = 5207;
  localparam int unsigned BAUD_DIV_115200 = 433;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate counter: counts 0..BAUD_DIV while enabled and pulses o_tick for
// the single cycle in which the count sits at BAUD_DIV, wrapping to 0 on the
// same edge so every bit period starts from a clean count.
//
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset
//   i_clear  - synchronous clear, holds the count at 0 (has priority)
//   i_enable - advance the count
//   o_tick   - last cycle of the current bit period

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_9600
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CntW = cnt_width(BAUD_DIV);

  logic [CntW-1:0] r_count;
  logic            w_at_max;

  assign w_at_max = (r_count == CntW'(BAUD_DIV));
  assign o_tick   = i_enable && w_at_max;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_max ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter. Requester 0 (core stdout) and requester 1
// (debug/status) share one serial line; contention is resolved round-robin
// against the most recently granted requester. Frames are 1 start bit,
// DATA_BITS payload bits LSB first, optional even parity, 1 stop bit.
//
// Ports:
//   clk            - clock, all state changes on its rising edge
//   nRst           - asynchronous active-low reset
//   req0_valid_i   - requester 0 has a byte
//   req0_data_i    - requester 0 byte
//   req0_ready_o   - requester 0 byte accepted this cycle
//   req1_valid_i   - requester 1 has a byte
//   req1_data_i    - requester 1 byte
//   req1_ready_o   - requester 1 byte accepted this cycle
//   TX             - registered serial line, idle high
//   busy_o         - frame in progress
//   last_grant_o   - index of the most recently granted requester
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between
// the payload and the stop bit.

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_9600,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 req0_valid_i,
  input  logic [DATA_BITS-1:0] req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [DATA_BITS-1:0] req1_data_i,
  output logic                 req1_ready_o,
  output logic                 TX,
  output logic                 busy_o,
  output logic                 last_grant_o
);

  localparam int unsigned    BitW    = cnt_width(DATA_BITS - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BitW-1:0]      r_bit_cnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_last_grant;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_idle;
  logic                 w_run;
  logic                 w_sel;
  logic                 w_xfer;
  logic                 w_tick;
  logic [DATA_BITS-1:0] w_data;

  assign w_idle = (r_state == StIdle);
  assign w_run  = !w_idle;

  // Single requester wins outright; on contention the one not granted last.
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_sel = ~r_last_grant;
    end else begin
      w_sel = req1_valid_i;
    end
  end

  assign req0_ready_o = w_idle && req0_valid_i && !w_sel;
  assign req1_ready_o = w_idle && req1_valid_i && w_sel;
  assign w_xfer       = req0_ready_o || req1_ready_o;
  assign w_data       = w_sel ? req1_data_i : req0_data_i;

  // Held cleared in IDLE so the start bit always gets a full period.
  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .i_clk   (clk),
    .i_rst_n (nRst),
    .i_clear (w_idle),
    .i_enable(w_run),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_shift      <= w_data;
            r_last_grant <= w_sel;
            r_bit_cnt    <= '0;
            r_tx         <= 1'b0;
            r_busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity     <= ^w_data;
`endif
            r_state      <= StStart;
          end
        end
        StStart: begin
          if (w_tick) begin
            // Shift register always presents the next bit at position 0.
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= StData;
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_bit_cnt == LastBit) begin
              r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_tx      <= r_parity;
              r_state   <= StParity;
`else
              r_tx      <= 1'b1;
              r_state   <= StStop;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= StStop;
          end
        end
`endif
        StStop: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign TX           = r_tx;
  assign busy_o       = r_busy;
  assign last_grant_o = r_last_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter at BAUD_DIV=3 (4 cycles per bit).
// A frame-level reference model predicts ready, TX, busy and last grant every
// cycle; a line decoder recovers bytes from TX and compares them with the
// bytes the model saw accepted. Define UART_TX_PARITY_EN to build the
// parity variant.

module tb_uart_tx_arbiter;

  localparam int unsigned BaudDiv  = 3;
  localparam int unsigned DataBits = 8;
  localparam int unsigned Cpb      = BaudDiv + 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FrameBits = DataBits + 3;
`else
  localparam int unsigned FrameBits = DataBits + 2;
`endif
  localparam int unsigned FrameCycles = Cpb * FrameBits;

  logic       clk  = 1'b0;
  logic       nRst = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       r0, r1, tx, busy, lg;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .BAUD_DIV (BaudDiv),
    .DATA_BITS(DataBits)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .req0_valid_i(v0),
    .req0_data_i (d0),
    .req0_ready_o(r0),
    .req1_valid_i(v1),
    .req1_data_i (d1),
    .req1_ready_o(r1),
    .TX          (tx),
    .busy_o      (busy),
    .last_grant_o(lg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus queues, one per requester, and the chance (%) of raising valid.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         chance = 100;
  bit         acc0 = 1'b0, acc1 = 1'b0;

  // Reference model state.
  bit                   m_active = 1'b0;
  int                   m_cyc = 0;
  logic                 m_lg = 1'b1;
  logic [FrameBits-1:0] m_frame = '1;
  logic [7:0]           exp_q[$];

  // Line decoder state.
  bit                   dec_active = 1'b0;
  int                   dec_cnt = 0;
  logic [FrameBits-1:0] dec_bits = '1;
  logic                 last_par = 1'b0;
  logic [7:0]           rx_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FrameBits-1:0] build_frame(input logic [7:0] d);
    logic [FrameBits-1:0] f;
    f                = '1;
    f[0]             = 1'b0;
    f[DataBits:1]    = d;
`ifdef UART_TX_PARITY_EN
    f[DataBits+1]    = ^d;
`endif
    return f;
  endfunction

  // Per-cycle model and decoder, evaluated mid-cycle.
  task automatic model_loop();
    logic [1:0] e_rdy;
    logic       e_sel;
    int         k;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_last_grant", lg, 1'b1);
        check_eq("rst_ready", {r1, r0}, 2'b00);
        m_active   = 1'b0;
        m_lg       = 1'b1;
        dec_active = 1'b0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        exp_q.delete();
      end else begin
        if (m_active) begin
          e_rdy = 2'b00;
          check_eq("tx_bit", tx, m_frame[m_cyc/Cpb]);
          check_eq("busy", busy, 1'b1);
        end else begin
          e_sel = (v0 && v1) ? !m_lg : v1;
          e_rdy = {v1 && e_sel, v0 && !e_sel};
          check_eq("idle_tx", tx, 1'b1);
          check_eq("idle_busy", busy, 1'b0);
        end
        check_eq("ready", {r1, r0}, e_rdy);
        check_eq("last_grant", lg, m_lg);
        acc0 = v0 && r0;
        acc1 = v1 && r1;
        if (m_active) begin
          m_cyc++;
          if (m_cyc == FrameCycles) m_active = 1'b0;
        end else if (e_rdy != 2'b00) begin
          m_lg     = e_rdy[1];
          m_frame  = build_frame(e_rdy[1] ? d1 : d0);
          exp_q.push_back(e_rdy[1] ? d1 : d0);
          m_active = 1'b1;
          m_cyc    = 0;
        end
        // Decoder: falling edge starts a frame, sample in the middle of each bit.
        if (!dec_active) begin
          if (tx == 1'b0) begin
            dec_active = 1'b1;
            dec_cnt    = 0;
          end
        end else begin
          dec_cnt++;
        end
        if (dec_active && (dec_cnt % Cpb) == Cpb / 2) begin
          k           = dec_cnt / Cpb;
          dec_bits[k] = tx;
          if (k == 0) check_eq("rx_start", tx, 1'b0);
          if (k == FrameBits - 1) begin
            check_eq("rx_stop", tx, 1'b1);
`ifdef UART_TX_PARITY_EN
            last_par = dec_bits[DataBits+1];
            check_eq("rx_parity", last_par, ^dec_bits[DataBits:1]);
`endif
            rx_log.push_back(dec_bits[DataBits:1]);
            if (exp_q.size() > 0) begin
              check_eq("rx_byte", dec_bits[DataBits:1], exp_q.pop_front());
            end else begin
              check_eq("rx_unexpected", 1'b1, 1'b0);
            end
            dec_active = 1'b0;
          end
        end
      end
    end
  endtask

  // Requester agents: raise valid with a queued byte, hold it until accepted.
  task automatic driver_loop();
    forever begin
      @(posedge clk);
      #1;
      if (acc0) begin
        if (q0.size() > 0) q0.delete(0);
        v0 = 1'b0;
      end
      if (acc1) begin
        if (q1.size() > 0) q1.delete(0);
        v1 = 1'b0;
      end
      if (!v0) begin
        if (q0.size() > 0 && int'($urandom_range(99)) < chance) begin
          v0 = 1'b1;
          d0 = q0[0];
        end else begin
          d0 = 8'($urandom);
        end
      end
      if (!v1) begin
        if (q1.size() > 0 && int'($urandom_range(99)) < chance) begin
          v1 = 1'b1;
          d1 = q1[0];
        end else begin
          d1 = 8'($urandom);
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || m_active || dec_active ||
            exp_q.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_in_budget", n < budget, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!busy && n < budget);
    check_eq("busy_in_budget", busy, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 nRst = 1'b0;
    repeat (2) @(posedge clk);
    #2 nRst = 1'b1;
  endtask

  // Compare decoded bytes against up to four expected bytes, byte i at [8i+:8].
  task automatic check_rx(input string tag, input int n, input logic [31:0] exp_bytes);
    check_eq({tag, "_count"}, rx_log.size(), n);
    for (int i = 0; i < n && i < rx_log.size(); i++) begin
      check_eq(tag, rx_log[i], exp_bytes[8*i+:8]);
    end
  endtask

  task automatic main_seq();
    int n_pushed;
    repeat (3) @(posedge clk);
    #2 nRst = 1'b1;

    // Quiet line after reset.
    repeat (100) @(posedge clk);

    // Single byte 'A' from requester 0.
    rx_log.delete();
    q0.push_back(8'h41);
    wait_drain(200);
    check_rx("decode_A", 1, 32'h41);

    // Contention straight after reset: requester 0 first, then requester 1.
    pulse_reset();
    rx_log.delete();
    q0.push_back(8'h55);
    q1.push_back(8'hAA);
    wait_drain(300);
    check_rx("contention", 2, 32'h0000_AA55);
    check_eq("contention_last_grant", lg, 1'b1);

    // Requester 1 arrives mid-frame and cuts in ahead of requester 0's backlog.
    rx_log.delete();
    q0.push_back(8'h10);
    q0.push_back(8'h11);
    q0.push_back(8'h12);
    repeat (20) @(posedge clk);
    q1.push_back(8'h99);
    wait_drain(600);
    check_rx("round_robin", 4, 32'h1211_9910);

    // Valid pulsed and withdrawn during a frame is ignored.
    rx_log.delete();
    q0.push_back(8'h3C);
    wait_busy(20);
    v1 = 1'b1;
    d1 = 8'hEE;
    @(posedge clk);
    #2 v1 = 1'b0;
    wait_drain(200);
    check_rx("withdrawn_valid", 1, 32'h3C);

    // Reset in the middle of data bit 4 aborts the frame.
    q0.push_back(8'hC3);
    wait_busy(20);
    repeat (21) @(posedge clk);
    #2;
    check_eq("pre_reset_tx", tx, 1'b0);
    nRst = 1'b0;
    #1;
    check_eq("async_rst_tx", tx, 1'b1);
    check_eq("async_rst_busy", busy, 1'b0);
    @(posedge clk);
    #2 nRst = 1'b1;
    rx_log.delete();
    q1.push_back(8'h0F);
    wait_drain(200);
    check_rx("after_abort", 1, 32'h0F);

`ifdef UART_TX_PARITY_EN
    rx_log.delete();
    q0.push_back(8'h07);
    wait_drain(200);
    check_rx("parity_byte", 1, 32'h07);
    check_eq("parity_bit", last_par, 1'b1);
`endif

    // Randomised traffic from both requesters.
    rx_log.delete();
    chance   = 40;
    n_pushed = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      if ($urandom_range(1) == 1) q0.push_back(8'($urandom));
      else q1.push_back(8'($urandom));
      n_pushed++;
      if ($urandom_range(3) == 0) begin
        q0.push_back(8'($urandom));
        q1.push_back(8'($urandom));
        n_pushed += 2;
      end
    end
    wait_drain(20000);
    check_eq("random_count", rx_log.size(), n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic watchdog();
    #900_000;
    check_eq("watchdog", 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "time limit reached");
  endtask

  initial begin
    fork
      main_seq();
      model_loop();
      driver_loop();
      watchdog();
    join_any
  end

endmodule
